// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: decodes legality, drives a request/ready bus
// through an IDLE/BUSY/DONE handshake, and extends load data for writeback.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignedM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] read_data_q, read_data_d;
    logic [2:0]  req_funct3_q, req_funct3_d;
    logic [1:0]  req_off_q, req_off_d;

    logic        mem_op_s;
    logic        legal_s;
    logic        access_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s;

    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = word;
        endcase
    endfunction

    // Legality decode and store lane formatting from the live M-stage inputs.
    always_comb begin
        mem_op_s = MemReadM | MemWriteM;
        case (Funct3M)
            3'b000:  legal_s = 1'b1;
            3'b001:  legal_s = ~ALUResultM[0];
            3'b010:  legal_s = (ALUResultM[1:0] == 2'b00);
            3'b100:  legal_s = ~MemWriteM;
            3'b101:  legal_s = ~MemWriteM & ~ALUResultM[0];
            default: legal_s = 1'b0;
        endcase
        access_s = mem_op_s & legal_s;
        if (MemWriteM) begin
            case (Funct3M)
                3'b000:  wstrb_s = 4'b0001 << ALUResultM[1:0];
                3'b001:  wstrb_s = 4'b0011 << ALUResultM[1:0];
                3'b010:  wstrb_s = 4'b1111;
                default: wstrb_s = 4'b0000;
            endcase
        end else begin
            wstrb_s = 4'b0000;
        end
        case (Funct3M[1:0])
            2'b00:   wdata_s = {4{WriteDataM[7:0]}};
            2'b01:   wdata_s = {2{WriteDataM[15:0]}};
            default: wdata_s = WriteDataM;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE always falls back to IDLE after one cycle.
    always_comb begin
        case (state_q)
            IDLE:    state_d = access_s ? BUSY : IDLE;
            BUSY:    state_d = mem_ready ? DONE : BUSY;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus and result register updates; BUSY works only from the captured request.
    always_comb begin
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        read_data_d  = read_data_q;
        req_funct3_d = req_funct3_q;
        req_off_d    = req_off_q;
        if ((state_q == IDLE) && access_s) begin
            mem_req_d    = 1'b1;
            mem_we_d     = MemWriteM;
            mem_addr_d   = {ALUResultM[31:2], 2'b00};
            mem_wdata_d  = wdata_s;
            mem_wstrb_d  = wstrb_s;
            req_funct3_d = Funct3M;
            req_off_d    = ALUResultM[1:0];
        end else if ((state_q == BUSY) && mem_ready) begin
            mem_req_d = 1'b0;
            if (!mem_we_q) begin
                read_data_d = load_extend(req_funct3_q, req_off_q, mem_rdata);
            end else begin
                read_data_d = read_data_q;
            end
        end else begin
            mem_req_d = mem_req_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'd0;
            read_data_q  <= 32'd0;
            req_funct3_q <= 3'd0;
            req_off_q    <= 2'd0;
        end else begin
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            read_data_q  <= read_data_d;
            req_funct3_q <= req_funct3_d;
            req_off_q    <= req_off_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign ReadDataM   = read_data_q;
    assign StallM      = access_s & (state_q != DONE);
    assign MisalignedM = mem_op_s & ~legal_s;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit, checked against an
// arithmetic model of access legality, lane formatting and load extension.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignedM;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rd = 32'd0;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignedM(MisalignedM)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (wr && f3 >= 3'd4) return 1'b0;
        return (a % size_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        int sz;
        logic [31:0] mask, v;
        sz   = size_of(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = (word >> (8 * (a % 4))) & mask;
        if (f3 < 3'd4 && sz < 4 && ((v >> (8 * sz - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_cycle();
        MemReadM = 1'b0; MemWriteM = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("idle_stall", {31'd0, StallM}, 32'd0);
        chk("idle_mis", {31'd0, MisalignedM}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Entered 1 time unit after a rising edge with the unit in IDLE.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdata, input int dly);
        logic ok;
        int sz, stalls;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        ok = (rd | wr) && model_legal(wr, f3, a);
        sz = size_of(f3);
        e_strb  = wr ? 4'(((1 << sz) - 1) << (a % 4)) : 4'd0;
        e_wdata = (sz == 1) ? wd[7:0] * 32'h0101_0101 : (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
        mem_ready = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        chk("first_mis", {31'd0, MisalignedM}, {31'd0, (rd | wr) & ~ok});
        chk("first_stall", {31'd0, StallM}, {31'd0, ok});
        chk("first_req", {31'd0, mem_req}, 32'd0);
        if (!ok) begin
            @(posedge clk); #1;
            chk("illegal_req", {31'd0, mem_req}, 32'd0);
            chk("illegal_stall", {31'd0, StallM}, 32'd0);
            chk("illegal_rdata", ReadDataM, model_rd);
        end else begin
            stalls = int'(StallM);
            for (int c = 0; c <= dly; c++) begin
                @(posedge clk); #1;
                mem_ready = (c == dly);
                mem_rdata = (c == dly) ? rdata : $urandom;
                @(negedge clk);
                chk("busy_req", {31'd0, mem_req}, 32'd1);
                chk("busy_we", {31'd0, mem_we}, {31'd0, wr});
                chk("busy_addr", mem_addr, {a[31:2], 2'b00});
                chk("busy_strb", {28'd0, mem_wstrb}, {28'd0, e_strb});
                if (wr) chk("busy_wdata", mem_wdata, e_wdata);
                stalls += int'(StallM);
            end
            @(posedge clk); #1;
            mem_ready = 1'b0; mem_rdata = $urandom;
            if (!wr) model_rd = model_load(f3, a, rdata);
            @(negedge clk);
            chk("done_req", {31'd0, mem_req}, 32'd0);
            chk("done_stall", {31'd0, StallM}, 32'd0);
            chk("done_rdata", ReadDataM, model_rd);
            chk("stall_cycles", stalls, dly + 2);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h100; WriteDataM = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_strb", {28'd0, mem_wstrb}, 32'd0);
        MemReadM = 1'b0;
        rst = 1'b0;
        idle_cycle();

        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0);
        chk("lw_const", ReadDataM, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_FFFF, 0);
        chk("lb_const", ReadDataM, 32'hFFFF_FF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_FFFF, 1);
        chk("lbu_const", ReadDataM, 32'h0000_0080);
        do_access(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 32'd0, 2);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("sh_strb", {28'd0, mem_wstrb}, 32'h0000_000C);
        do_access(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 0);
        do_access(1'b0, 1'b1, 3'b011, 32'h40, 32'h55, 32'd0, 0);
        do_access(1'b1, 1'b1, 3'b000, 32'h41, 32'hA5, 32'h0, 0);
        chk("both_is_store_rdata", ReadDataM, 32'h0000_0080);
        do_access(1'b0, 1'b1, 3'b100, 32'h40, 32'h55, 32'd0, 0);
        do_access(1'b1, 1'b0, 3'b101, 32'h45, 32'd0, 32'd0, 0);

        // SW immediately followed by LW.
        do_access(1'b0, 1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, 32'd0, 1);
        do_access(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, 32'h1357_9BDF, 0);

        // Reset while BUSY, then a late ready in IDLE.
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h300;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1; MemReadM = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        model_rd = 32'd0;
        @(negedge clk);
        chk("midrst_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_we", {31'd0, mem_we}, 32'd0);
        chk("midrst_addr", mem_addr, 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        chk("midrst_rdata", ReadDataM, 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("late_ready_rdata", ReadDataM, 32'd0);
        chk("late_ready_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            if (op == 2'd3) begin
                idle_cycle();
            end else begin
                do_access(op != 2'd1, op != 2'd0, 3'($urandom_range(0, 7)), a,
                          $urandom, $urandom, $urandom_range(0, 3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have the following ports, in this order:
- clk  in  1  rising-edge clock; one clock only.
- rst  in  1  synchronous, active-high reset.
- MemReadM  in  1  load in memory stage.
- MemWriteM  in  1  store in memory stage.
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultM  in  32  byte address from execute.
- WriteDataM  in  32  store data, low-aligned.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables.
- mem_ready  in  1  bus completion.
- mem_rdata  in  32  bus read word.
- ReadDataM  out  32  extended load result.
- StallM  out  1  freeze pipeline stages F/D/E/M.
- MisalignedM  out  1  illegal or misaligned access flag.

Function
REQ-002 The FSM SHALL have exactly three states: IDLE, BUSY and DONE, with state held in a register.
REQ-003 An access SHALL be defined as (MemReadM|MemWriteM) AND legal, where legal means Funct3 is valid for the operation, H/HU has addr[0]=0, and W has addr[1:0]=00.
REQ-004 Stores SHALL accept only Funct3 000/001/010; any other store Funct3 is illegal.
REQ-005 In IDLE with an access, the next state SHALL be BUSY.
- On that edge, mem_req<=1, mem_we<=MemWriteM, and addr/wdata/wstrb are registered.
REQ-006 In BUSY, while mem_ready=0, the block SHALL hold all bus outputs stable.
REQ-007 In BUSY with mem_ready=1, the next state SHALL be DONE.
- mem_req<=0.
- For loads, ReadDataM<=extend(mem_rdata).
REQ-008 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-009 StallM SHALL equal access AND (state!=DONE), combinationally.
- Minimum load/store latency is therefore 2 stall cycles with the result usable in the DONE cycle.
REQ-010 mem_addr SHALL be {ALUResultM[31:2],2'b00}.
REQ-011 mem_wstrb SHALL be:
- B: 0001<<addr[1:0].
- H: 0011<<addr[1:0].
- W: 1111.
- Loads: 0000.
REQ-012 mem_wdata SHALL be:
- B: byte replicated x4.
- H: half replicated x2.
- W: unchanged.
REQ-013 Load extension SHALL select the byte/half at addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes the word through.
REQ-014 ReadDataM SHALL hold its last captured value between loads.
REQ-015 When MemReadM and MemWriteM are both 1, the access SHALL be treated as a store.
REQ-016 An illegal/misaligned access SHALL raise MisalignedM=1 combinationally, with:
- no bus request;
- StallM=0;
- state stays IDLE;
- ReadDataM unchanged.
REQ-017 With no memory operation, MisalignedM=0 and StallM=0.
REQ-018 If the inputs change while in BUSY (they must not, since the pipeline is stalled), the block SHALL use the registered request, not the live inputs.

Reset
REQ-019 With rst=1 at a clock edge, the block SHALL set state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0 and ReadDataM=0; this applies in every state, including mid-BUSY.
REQ-020 After a mid-transaction reset, the block SHALL ignore a late mem_ready received in IDLE.
REQ-021 rst SHALL take priority over all other inputs.

Verification
REQ-022 LW, addr 0x100, mem_ready on the 1st BUSY cycle, mem_rdata 0xDEADBEEF -> StallM=1 for 2 cycles, then DONE with ReadDataM=0xDEADBEEF and StallM=0.
REQ-023 LB, addr 0x103, rdata 0x80FFFFFF -> ReadDataM=0xFFFFFF80; LBU, same inputs -> ReadDataM=0x00000080.
REQ-024 SH, addr 0x22, WriteDataM=0x1234ABCD -> mem_we=1, mem_addr=0x20, mem_wstrb=1100, mem_wdata=0xABCDABCD; mem_ready delayed 3 cycles -> StallM=1 for 4 cycles and bus outputs stable throughout.
REQ-025 LW at 0x102 -> MisalignedM=1, mem_req stays 0, StallM=0; store with Funct3=011 -> same response.
REQ-026 rst asserted during BUSY, mem_ready=1 the next cycle -> state IDLE, mem_req=0, ReadDataM=0, and no DONE cycle occurs.
REQ-027 Back-to-back SW then LW with no idle cycle between them -> the second request issues from IDLE on the cycle after DONE, and both complete in order.
